// File: rtl/jt12_cic_dec.sv
// Third-order CIC decimator for the jt12_dac2 1-bit stream; R = 2**RW, signed PCM out.
// Optional JT12_CIC_PRIME_EN: suppress dout_valid for the first three strobes after reset.
module jt12_cic_dec #(
  parameter int RW   = 4,
  parameter int WOUT = 3*RW+2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cen,
  input  logic                   din,
  output logic signed [WOUT-1:0] dout,
  output logic                   dout_valid
);

  logic signed [WOUT-1:0] x;
  logic signed [WOUT-1:0] i1, i2, i3;
  logic signed [WOUT-1:0] s;
  logic signed [WOUT-1:0] d1, d2, d3;
  logic signed [WOUT-1:0] c1, c2, c3;
  logic [RW-1:0]          cnt;
  logic                   dec_pt;
  logic                   comb_pend;
  logic                   strobe_ok;

  // din=1 -> +1 (0..01), din=0 -> -1 (1..11)
  assign x      = {{(WOUT-1){~din}}, 1'b1};
  assign dec_pt = cen && (cnt == '1);

  // Integrator section, running at the cen rate; wraps modulo 2**WOUT by design
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i1  <= '0;
      i2  <= '0;
      i3  <= '0;
      s   <= '0;
      cnt <= '0;
    end else if (cen) begin
      i1  <= i1 + x;
      i2  <= i2 + i1;
      i3  <= i3 + i2;
      cnt <= cnt + RW'(1);
      if (cnt == '1)
        s <= i3;
    end
  end

  // Comb section runs on the edge right after the decimation edge, regardless of cen
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      comb_pend <= 1'b0;
    else
      comb_pend <= dec_pt;
  end

  always_comb begin
    c1 = s  - d1;
    c2 = c1 - d2;
    c3 = c2 - d3;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d1         <= '0;
      d2         <= '0;
      d3         <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= comb_pend && strobe_ok;
      if (comb_pend) begin
        d1   <= s;
        d2   <= c1;
        d3   <= c2;
        dout <= c3;
      end
    end
  end

`ifdef JT12_CIC_PRIME_EN
  logic [1:0] prime;

  // Counts strobes until the comb delay line holds only post-reset samples, then saturates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      prime <= '0;
    else if (comb_pend && (prime != 2'd3))
      prime <= prime + 2'd1;
  end

  assign strobe_ok = (prime == 2'd3);
`else
  assign strobe_ok = 1'b1;
`endif

endmodule

// File: tb/tb_jt12_cic_dec.sv
// Self-checking bench for jt12_cic_dec: directed vectors plus randomized stream vs. a closed-form reference.
module tb_jt12_cic_dec;

  localparam int RW   = 4;
  localparam int WOUT = 14;
  localparam int R    = 16;
`ifdef JT12_CIC_PRIME_EN
  localparam int FIRST_K = 4;
`else
  localparam int FIRST_K = 1;
`endif
  localparam int EXP_LAT = R*FIRST_K + 1;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   cen = 1'b0;
  logic                   din = 1'b0;
  logic signed [WOUT-1:0] dout;
  logic                   dout_valid;

  jt12_cic_dec #(.RW(RW), .WOUT(WOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cen        (cen),
    .din        (din),
    .dout       (dout),
    .dout_valid (dout_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            cyc;
    logic [13:0]   val;
    int            k;
  } exp_t;

  typedef struct {
    logic [3:0] pat;
    int         plen;
    int         cper;
    int         steady;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          nvalid = 0;
  int          xs[$];
  exp_t        q[$];
  int          n_cen = 0;
  int          k_str = 0;
  longint      s1 = 0, s2 = 0, s3 = 0;
  logic [13:0] held = '0;
  bit          steady_en = 0;
  int          steady_exp = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Integrator output after n cen edges equals sum x[m]*C(n-m,2); sample s_k is that at n = R*k-1
  function automatic longint s_at(int k);
    longint acc = 0;
    int nn = R*k - 1;
    for (int m = 1; m <= nn; m++) begin
      longint w = longint'(nn - m) * longint'(nn - m - 1) / 2;
      acc += longint'(xs[m-1]) * w;
    end
    return acc;
  endfunction

  task automatic model_clear();
    xs.delete();
    q.delete();
    n_cen = 0;
    k_str = 0;
    s1 = 0; s2 = 0; s3 = 0;
    held = '0;
  endtask

  task automatic model_edge();
    longint sk, val;
    exp_t e;
    cyc++;
    if (!rst_n) begin
      model_clear();
      return;
    end
    if (cen) begin
      xs.push_back(din ? 1 : -1);
      n_cen++;
      if (n_cen % R == 0) begin
        k_str++;
        sk  = s_at(k_str);
        val = sk - 3*s1 + 3*s2 - s3;
        s3 = s2; s2 = s1; s1 = sk;
        e.cyc = cyc + 1;
        e.val = val[13:0];
        e.k   = k_str;
        q.push_back(e);
      end
    end
  endtask

  task automatic monitor();
    exp_t e;
    bit hit = 0;
    int ev = 0;
    if (q.size() > 0 && q[0].cyc == cyc) begin
      e    = q.pop_front();
      hit  = 1;
      held = e.val;
      ev   = (e.k >= FIRST_K) ? 1 : 0;
    end
    chk("dout_valid", int'(dout_valid), ev);
    chk("dout", int'(dout), int'($signed(held)));
    if (hit && steady_en && e.k >= 4)
      chk("steady_dout", int'(dout), steady_exp);
    if (dout_valid) nvalid++;
  endtask

  // Drive inputs, let the DUT take one edge, then compare on the falling edge
  task automatic step(input logic d, input logic c, input logic r);
    din = d; cen = c; rst_n = r;
    if (!r) model_clear();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    monitor();
  endtask

  task automatic run(input int ncyc, input logic [3:0] pat, input int plen, input int cper);
    logic [3:0] pv;
    int p = 0;
    for (int j = 0; j < ncyc; j++) begin
      logic c;
      c  = (j % cper) == 0;
      pv = pat;
      step(pv[p % plen], c, 1'b1);
      if (c) p++;
    end
  endtask

  task automatic measure_latency(output int lat);
    lat = 0;
    for (int e = 1; e <= 100 && lat == 0; e++) begin
      step(1'b1, 1'b1, 1'b1);
      if (dout_valid) lat = e;
    end
  endtask

  vec_t vecs[6];

  initial begin
    int lat, nv0, exp_nv;

    vecs[0] = '{pat: 4'b0001, plen: 1, cper: 1, steady:  4096};
    vecs[1] = '{pat: 4'b0000, plen: 1, cper: 1, steady: -4096};
    vecs[2] = '{pat: 4'b0111, plen: 4, cper: 1, steady:  2048};
    vecs[3] = '{pat: 4'b0001, plen: 2, cper: 1, steady:     0};
    vecs[4] = '{pat: 4'b0001, plen: 1, cper: 3, steady:  4096};
    vecs[5] = '{pat: 4'b0001, plen: 4, cper: 1, steady: -2048};

    // Reset held with cen active and din toggling
    for (int j = 0; j < 10; j++) step(j[0], 1'b1, 1'b0);
    chk("rst_dout", int'(dout), 0);
    chk("rst_valid", int'(dout_valid), 0);

    measure_latency(lat);
    chk("first_valid_latency", lat, EXP_LAT);
    steady_en = 1; steady_exp = 4096;
    run(8*R, 4'b0001, 1, 1);

    // Full-scale step from +1 to -1 input
    steady_en = 0;
    run(5*R, 4'b0000, 1, 1);
    chk("switch_neg", int'(dout), -4096);

    run(6*R + 5, 4'b0001, 1, 1);
    chk("pre_rst_dout", int'(dout), 4096);
    rst_n = 1'b0;
    model_clear();
    #1;
    chk("midrst_dout", int'(dout), 0);
    chk("midrst_valid", int'(dout_valid), 0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    measure_latency(lat);
    chk("post_rst_latency", lat, EXP_LAT);
    steady_en = 1; steady_exp = 4096;
    run(8*R, 4'b0001, 1, 1);

    for (int v = 0; v < 6; v++) begin
      steady_en = 0;
      for (int j = 0; j < 3; j++) step(1'b0, 1'b1, 1'b0);
      steady_en  = 1;
      steady_exp = vecs[v].steady;
      nv0 = nvalid;
      run(9*R*vecs[v].cper + 2, vecs[v].pat, vecs[v].plen, vecs[v].cper);
      exp_nv = 9 - (FIRST_K - 1);
      chk($sformatf("row%0d_strobes", v), nvalid - nv0, exp_nv);
    end

    // Random stream with random cen gaps and one reset mid-run
    steady_en = 0;
    for (int j = 0; j < 3; j++) step(1'b0, 1'b1, 1'b0);
    for (int j = 0; j < 3000; j++) begin
      logic d, c, r;
      d = 1'($urandom_range(0, 1));
      c = ($urandom_range(0, 3) != 0);
      r = !(j >= 1500 && j < 1502);
      step(d, c, r);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
